// File: rtl/btn_debounce_pkg.sv
// Shared definitions for the push-button debouncer: channel FSM encoding and button bit indices.
// Optional auto-repeat is enabled with `define BTN_DEBOUNCE_AUTO_REPEAT_EN.
package btn_debounce_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_PRESS_CHK = 2'd1,
    ST_PRESSED   = 2'd2,
    ST_REL_CHK   = 2'd3
  } btn_state_e;

  // Bit positions inside the {btnd, btnr, btnu, btnl, btnc} bus.
  localparam int BTN_C = 0;
  localparam int BTN_L = 1;
  localparam int BTN_U = 2;
  localparam int BTN_R = 3;
  localparam int BTN_D = 4;

endpackage

// File: rtl/btn_debounce_cell.sv
// One debounce channel: 2-flop synchronizer, qualify FSM with stability counter, press pulse.
// With `define BTN_DEBOUNCE_AUTO_REPEAT_EN a held button also emits periodic repeat pulses.
module btn_debounce_cell
  import btn_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
`ifdef BTN_DEBOUNCE_AUTO_REPEAT_EN
  ,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 10000000
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic level_o,
  output logic pulse_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_ff1_q;
  logic             sync_q;
  btn_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             level_q;
  logic             pulse_q;

`ifdef BTN_DEBOUNCE_AUTO_REPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);

  logic [RPT_W-1:0] rpt_q;
  logic             rpt_arm_q;  // 0: waiting for first repeat, 1: periodic phase
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_ff1_q <= 1'b0;
      sync_q     <= 1'b0;
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      level_q    <= 1'b0;
      pulse_q    <= 1'b0;
`ifdef BTN_DEBOUNCE_AUTO_REPEAT_EN
      rpt_q      <= '0;
      rpt_arm_q  <= 1'b0;
`endif
    end else begin
      sync_ff1_q <= btn_i;
      sync_q     <= sync_ff1_q;
      pulse_q    <= 1'b0;
`ifdef BTN_DEBOUNCE_AUTO_REPEAT_EN
      // Repeat state only survives while sitting in PRESSED with the button held.
      rpt_q      <= '0;
      rpt_arm_q  <= 1'b0;
`endif
      case (state_q)
        ST_IDLE: begin
          if (sync_q) begin
            state_q <= ST_PRESS_CHK;
            cnt_q   <= '0;
          end
        end
        ST_PRESS_CHK: begin
          if (!sync_q) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= ST_PRESSED;
            cnt_q   <= '0;
            level_q <= 1'b1;
            pulse_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_PRESSED: begin
          if (!sync_q) begin
            state_q <= ST_REL_CHK;
            cnt_q   <= '0;
          end else begin
`ifdef BTN_DEBOUNCE_AUTO_REPEAT_EN
            if (rpt_q == (rpt_arm_q ? RPT_W'(REPEAT_PERIOD - 1) : RPT_W'(REPEAT_DELAY))) begin
              pulse_q   <= 1'b1;
              rpt_q     <= '0;
              rpt_arm_q <= 1'b1;
            end else begin
              rpt_q     <= rpt_q + RPT_W'(1);
              rpt_arm_q <= rpt_arm_q;
            end
`endif
          end
        end
        ST_REL_CHK: begin
          if (sync_q) begin
            state_q <= ST_PRESSED;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            level_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign level_o = level_q;
  assign pulse_o = pulse_q;

endmodule

// File: rtl/btn_debounce.sv
// Debounces N_BTN asynchronous push-buttons into clean levels and single-cycle press pulses.
// Optional auto-repeat on held buttons via `define BTN_DEBOUNCE_AUTO_REPEAT_EN.
module btn_debounce
  import btn_debounce_pkg::*;
#(
  parameter int N_BTN           = 5,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES),
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_in,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_pulse
);

  if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
    $error("btn_debounce: DEBOUNCE_CYCLES must be >= 2 and repeat timings >= 1");
  end

  // Channels are fully independent; simultaneous pulses are passed through unarbitrated.
  for (genvar i = 0; i < N_BTN; i++) begin : g_chan
    btn_debounce_cell #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
`ifdef BTN_DEBOUNCE_AUTO_REPEAT_EN
      ,
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
`endif
    ) u_cell (
      .clk     (clk),
      .rst     (rst),
      .btn_i   (btn_in[i]),
      .level_o (btn_level[i]),
      .pulse_o (btn_pulse[i])
    );
  end

endmodule

// File: tb/tb_btn_debounce.sv
// Bench for btn_debounce: directed vector table for the corner cases, then random
// button activity checked against a run-length model of the debounce rules.
module tb_btn_debounce;

  localparam int N  = 5;
  localparam int D  = 4;
  localparam int RD = 20;
  localparam int RP = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] btn_in;
  logic [N-1:0] btn_level;
  logic [N-1:0] btn_pulse;

  always #5 clk = ~clk;

  btn_debounce #(
    .N_BTN           (N),
    .DEBOUNCE_CYCLES (D),
    .CNT_W           ($clog2(D)),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_in    (btn_in),
    .btn_level (btn_level),
    .btn_pulse (btn_pulse)
  );

  typedef struct {
    logic         rst;
    logic [N-1:0] btn;
    logic [N-1:0] lvl;
    logic [N-1:0] pls;
  } vec_t;

  vec_t         vecs[$];
  logic [2*N-1:0] exp_q[$];
  int           n_checks = 0;
  int           n_pass   = 0;

  // Reference model: each input is seen two edges late; the level flips once the seen
  // value has differed from it for D+1 consecutive edges.
  logic [N-1:0] m_p1, m_p2, m_level, m_pulse;
  int           m_run[N];
`ifdef BTN_DEBOUNCE_AUTO_REPEAT_EN
  int           m_t[N];
`endif

  function automatic void add(input logic r, input logic [N-1:0] b,
                              input logic [N-1:0] l, input logic [N-1:0] p);
    vec_t v;
    v.rst = r; v.btn = b; v.lvl = l; v.pls = p;
    vecs.push_back(v);
  endfunction

  task automatic model_edge(input logic r, input logic [N-1:0] b);
    if (r) begin
      m_p1 = '0; m_p2 = '0; m_level = '0; m_pulse = '0;
      for (int c = 0; c < N; c++) begin
        m_run[c] = 0;
`ifdef BTN_DEBOUNCE_AUTO_REPEAT_EN
        m_t[c] = 0;
`endif
      end
    end else begin
      for (int c = 0; c < N; c++) begin
        logic s;
        s = m_p2[c];
        m_pulse[c] = 1'b0;
        if (s != m_level[c]) begin
          m_run[c]++;
          if (m_run[c] == D + 1) begin
            m_level[c] = s;
            m_run[c]   = 0;
            if (s) m_pulse[c] = 1'b1;
`ifdef BTN_DEBOUNCE_AUTO_REPEAT_EN
            m_t[c] = 0;
`endif
          end
        end else begin
`ifdef BTN_DEBOUNCE_AUTO_REPEAT_EN
          if (s) begin
            if (m_run[c] > 0) m_t[c] = 0;
            else begin
              m_t[c]++;
              if (m_t[c] == RD + 1 || (m_t[c] > RD + 1 && (m_t[c] - RD - 1) % RP == 0))
                m_pulse[c] = 1'b1;
            end
          end
`endif
          m_run[c] = 0;
        end
      end
      m_p2 = m_p1;
      m_p1 = b;
    end
  endtask

  // Drive one cycle of inputs, advance the model on the edge, check #1 later.
  task automatic cycle(input logic r, input logic [N-1:0] b, input logic use_tab,
                       input logic [N-1:0] tl, input logic [N-1:0] tp,
                       input string name, input int idx);
    logic [2*N-1:0] exp_v;
    rst    = r;
    btn_in = b;
    @(posedge clk);
    model_edge(r, b);
    exp_q.push_back(use_tab ? {tl, tp} : {m_level, m_pulse});
    #1;
    exp_v = exp_q.pop_front();
    n_checks++;
    if ({btn_level, btn_pulse} === exp_v) n_pass++;
    else $display("FAIL %s #%0d: level=%b pulse=%b, expected level=%b pulse=%b",
                  name, idx, btn_level, btn_pulse, exp_v[2*N-1:N], exp_v[N-1:0]);
  endtask

  initial begin
    logic [N-1:0] cur;
    logic [N-1:0] rp;
    rst = 1'b1;
    btn_in = '0;

    // Reset state
    add(1'b1, 5'b00000, 5'b00000, 5'b00000);
    // Clean press and release on btnd
    for (int j = 0; j < 20; j++) add(1'b0, 5'b10000, j >= 6 ? 5'b10000 : 5'b0, j == 6 ? 5'b10000 : 5'b0);
    for (int j = 0; j < 10; j++) add(1'b0, 5'b00000, j < 6 ? 5'b10000 : 5'b0, 5'b0);
    // Bounce shorter than the qualify window on btnc
    for (int j = 0; j < 14; j++) add(1'b0, (j < 8 && (j % 4) < 2) ? 5'b00001 : 5'b0, 5'b0, 5'b0);
    // Release glitch on btnl, then a real release
    for (int j = 0; j < 10; j++) add(1'b0, 5'b00010, j >= 6 ? 5'b00010 : 5'b0, j == 6 ? 5'b00010 : 5'b0);
    for (int j = 0; j < 2; j++)  add(1'b0, 5'b00000, 5'b00010, 5'b0);
    for (int j = 0; j < 6; j++)  add(1'b0, 5'b00010, 5'b00010, 5'b0);
    for (int j = 0; j < 10; j++) add(1'b0, 5'b00000, j < 6 ? 5'b00010 : 5'b0, 5'b0);
    // Simultaneous press of btnd and btnc
    for (int j = 0; j < 10; j++) add(1'b0, 5'b10001, j >= 6 ? 5'b10001 : 5'b0, j == 6 ? 5'b10001 : 5'b0);
    for (int j = 0; j < 10; j++) add(1'b0, 5'b00000, j < 6 ? 5'b10001 : 5'b0, 5'b0);
    // Reset mid-debounce with the button held through it
    for (int j = 0; j < 3; j++)  add(1'b0, 5'b10000, 5'b0, 5'b0);
    add(1'b1, 5'b10000, 5'b0, 5'b0);
    for (int j = 0; j < 12; j++) add(1'b0, 5'b10000, j >= 6 ? 5'b10000 : 5'b0, j == 6 ? 5'b10000 : 5'b0);
    for (int j = 0; j < 10; j++) add(1'b0, 5'b00000, j < 6 ? 5'b10000 : 5'b0, 5'b0);
    // Reset right after acceptance drops the level and re-qualifies the held button
    for (int j = 0; j < 7; j++)  add(1'b0, 5'b00100, j == 6 ? 5'b00100 : 5'b0, j == 6 ? 5'b00100 : 5'b0);
    add(1'b1, 5'b00100, 5'b0, 5'b0);
    for (int j = 0; j < 12; j++) add(1'b0, 5'b00100, j >= 6 ? 5'b00100 : 5'b0, j == 6 ? 5'b00100 : 5'b0);
    for (int j = 0; j < 10; j++) add(1'b0, 5'b00000, j < 6 ? 5'b00100 : 5'b0, 5'b0);
    // Long hold on btnr
    for (int j = 0; j < 61; j++) begin
`ifdef BTN_DEBOUNCE_AUTO_REPEAT_EN
      rp = (j == 6 || j == 27 || j == 35 || j == 43 || j == 51 || j == 59) ? 5'b01000 : 5'b0;
`else
      rp = (j == 6) ? 5'b01000 : 5'b0;
`endif
      add(1'b0, 5'b01000, j >= 6 ? 5'b01000 : 5'b0, rp);
    end
    for (int j = 0; j < 10; j++) add(1'b0, 5'b00000, j < 6 ? 5'b01000 : 5'b0, 5'b0);

    for (int i = 0; i < vecs.size(); i++)
      cycle(vecs[i].rst, vecs[i].btn, 1'b1, vecs[i].lvl, vecs[i].pls, "directed", i);

    // Random button activity with occasional resets, checked against the model.
    cur = '0;
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < N; c++)
        if ($urandom_range(0, 4) == 0) cur[c] = ~cur[c];
      cycle((i == 0) || ($urandom_range(0, 299) == 0), cur, 1'b0, '0, '0, "random", i);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
